ftu_word_serializer: RTL and testbench
======================================

// Module: ftu_word_serializer
// PURPOSE
// Generalised FIFO-to-transmitter serializer. Pops one N_BYTES-wide word from the TX FIFO and hands it
// byte by byte to xmit, with a one-cycle xmit strobe per byte and a wait for xmit_done.
// Runs on a single clock. Adds three features: parametrised word and byte width, a runtime trim mode
// that drops unused high bytes, and runtime byte order. Sits between the TX FIFO and xmit.
// PARAMETERS
// BYTE_W     8  bits per transmitted byte
// N_BYTES    8  bytes per FIFO word; FIFO word width = N_BYTES*BYTE_W
// MIN_BYTES  4  minimum byte count in trim mode. Legal range is 1..N_BYTES (elaboration error otherwise)
// CNT_W      derived localparam = $clog2(N_BYTES+1)
// PORTS
// sys_clk    in   1                  system clock; all logic runs on the rising edge
// sys_rst_l  in   1                  reset, asynchronous, active-high
// pndng      in   1                  FIFO not empty
// D_reg      in   N_BYTES*BYTE_W     FIFO read data; valid the cycle after pop
// pop        out  1                  FIFO read strobe, one cycle per word
// mode_trim  in   1                  1 = trim high zero bytes; 0 = always send N_BYTES bytes
// msb_first  in   1                  1 = send highest used byte first; 0 = send byte 0 first
// Dout       out  BYTE_W             byte presented to xmit
// xmit       out  1                  one-cycle start strobe to xmit
// xmit_done  in   1                  xmit finished the current byte (level or pulse)
// busy       out  1                  high in every state except IDLE
// word_done  out  1                  one-cycle pulse after the last byte of a word completes
// byte_idx   out  CNT_W              bytes already completed in the current word
// BEHAVIOUR
// - Reset: state=IDLE. word_q, len_q, cnt, mode flops = 0. All outputs 0, including Dout and byte_idx.
// - FSM: IDLE -> POP -> LOAD -> START -> WAIT -> (START | DONE) -> IDLE.
// - IDLE: busy=0. If pndng=1, go to POP; otherwise stay.
// - POP: pop=1 for exactly this cycle. Go to LOAD unconditionally.
// - LOAD: capture word_q <= D_reg. Capture trim_q <= mode_trim and msb_q <= msb_first. cnt <= 0.
//   len_q <= N_BYTES if mode_trim=0.
//   Otherwise len_q <= max(MIN_BYTES, index of highest nonzero byte + 1). An all-zero word gives MIN_BYTES.
// - START: xmit=1 for one cycle. Go to WAIT.
// - WAIT: sample xmit_done only in this state.
//   If xmit_done=1 and cnt==len_q-1, go to DONE.
//   Else if xmit_done=1, cnt <= cnt+1 and go to START.
//   Else stay in WAIT.
// - DONE: word_done=1 for one cycle. cnt <= 0. Go to IDLE.
// - Dout = word_q byte[sel]. sel = cnt when msb_q=0; sel = len_q-1-cnt when msb_q=1.
//   Dout is stable from the START cycle through the end of the WAIT cycle for each byte.
// - byte_idx = cnt.
// - Latency: pndng high in IDLE -> pop next cycle -> first xmit 2 cycles after pop.
//   Next byte's xmit comes 1 cycle after xmit_done is seen in WAIT.
// - Back-to-back words: with pndng held high, pop follows DONE after exactly one IDLE cycle.
//   pop never fires more than once per word.
// - pndng is ignored outside IDLE.
// - xmit_done is ignored in IDLE, POP, LOAD, START and DONE. A done asserted in the START cycle does not count.
// - mode_trim and msb_first changes take effect only at the next LOAD. A word in progress is never altered.
// - Reset mid-word: immediate return to IDLE with all outputs 0. The partially sent word is dropped
//   and not re-popped.
// - Byte select never exceeds N_BYTES-1. len_q is always in MIN_BYTES..N_BYTES in trim mode
//   and N_BYTES in full mode.
// TESTING (N_BYTES=8, BYTE_W=8, MIN_BYTES=4; xmit model returns xmit_done 5 cycles after each xmit)
// 1 Full, LSB first, D=64'h0807060504030201 -> Dout 01..08 on 8 xmit pulses; 1 pop; word_done after 8th done.
// 2 Trim, LSB first, D=64'h00000000A1B2C3D4 -> 4 bytes D4,C3,B2,A1; word_done; byte_idx counts 0..3.
// 3 Trim, MSB first, D=64'h0000110000000022 -> 6 bytes 11,00,00,00,00,22. All-zero word -> 4 bytes of 00.
// 4 Reset asserted after 3rd xmit -> next cycle all outputs 0, busy=0; next pndng pops a new word from byte 0.
// 5 pndng held high, 3 words queued -> exactly 3 pops, one IDLE cycle between DONE and each following POP.
// 6 xmit_done forced high during START and LOAD, and toggling mode_trim mid-word -> no skipped byte; word length unchanged.

Source files
------------

// File: rtl/ftu_word_serializer.sv
// ftu_word_serializer
// Pops one N_BYTES-wide word from the TX FIFO and hands it to xmit one
// byte at a time. Each byte gets a one-cycle xmit strobe, and the block
// then waits for xmit_done before it moves to the next byte.
//
// Runtime options are captured when the word is loaded:
//   mode_trim  1 = drop high all-zero bytes (never fewer than MIN_BYTES)
//   msb_first  1 = send the highest used byte first
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_l  in   asynchronous reset, active-high
//   pndng      in   FIFO not empty (looked at only in IDLE)
//   D_reg      in   FIFO read data, valid the cycle after pop
//   pop        out  FIFO read strobe, one cycle per word
//   mode_trim  in   trim mode select
//   msb_first  in   byte order select
//   Dout       out  byte presented to xmit
//   xmit       out  one-cycle start strobe for the current byte
//   xmit_done  in   xmit finished the current byte (looked at only in WAIT)
//   busy       out  high in every state except IDLE
//   word_done  out  one-cycle pulse after the last byte of a word
//   byte_idx   out  bytes already completed in the current word
//   state_dbg  out  {trim_q, msb_q, fsm state} for checkers
//
// Handshake: pop and xmit are single-cycle strobes with no ready. The FIFO
// presents the word on D_reg in the cycle after pop. xmit_done is a
// level or a pulse. It counts only in WAIT, so a done that is still high
// from the previous byte, or one raised in the START cycle, cannot skip a byte.
module ftu_word_serializer #(
  parameter  int BYTE_W    = 8,
  parameter  int N_BYTES   = 8,
  parameter  int MIN_BYTES = 4,
  localparam int CNT_W     = $clog2(N_BYTES + 1),
  localparam int WORD_W    = N_BYTES * BYTE_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic              pndng,
  input  logic [WORD_W-1:0] D_reg,
  output logic              pop,
  input  logic              mode_trim,
  input  logic              msb_first,
  output logic [BYTE_W-1:0] Dout,
  output logic              xmit,
  input  logic              xmit_done,
  output logic              busy,
  output logic              word_done,
  output logic [CNT_W-1:0]  byte_idx,
  output logic [4:0]        state_dbg
);

  if (MIN_BYTES < 1 || MIN_BYTES > N_BYTES) begin : g_bad_min_bytes
    $error("ftu_word_serializer: MIN_BYTES must be in 1..N_BYTES");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [WORD_W-1:0]  word_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt;
  logic               trim_q;
  logic               msb_q;

  logic [CNT_W-1:0]   hi_len;
  logic [CNT_W-1:0]   trim_len;
  logic [CNT_W-1:0]   sel;
  logic               last_byte;

  // Length in trim mode: index of the highest nonzero byte plus one,
  // with MIN_BYTES as the floor. An all-zero word gives MIN_BYTES.
  always_comb begin
    hi_len = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (D_reg[i*BYTE_W +: BYTE_W] != '0) hi_len = CNT_W'(i + 1);
    end
    trim_len = (hi_len < CNT_W'(MIN_BYTES)) ? CNT_W'(MIN_BYTES) : hi_len;
  end

  assign last_byte = (cnt == len_q - CNT_W'(1));

  // When MSB first, count down from the highest used byte. cnt < len_q
  // <= N_BYTES, so sel always stays inside the word. The compare loop
  // avoids indexing with a wider-than-needed select.
  always_comb begin
    sel  = msb_q ? (len_q - CNT_W'(1) - cnt) : cnt;
    Dout = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (sel == CNT_W'(i)) Dout = word_q[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_l) begin
    if (sys_rst_l) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    xmit      = 1'b0;
    word_done = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (pndng) state_nx = S_POP;
      S_POP: begin
        pop      = 1'b1;
        state_nx = S_LOAD;
      end
      S_LOAD:  state_nx = S_START;
      S_START: begin
        xmit     = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (xmit_done) state_nx = last_byte ? S_DONE : S_START;
      end
      S_DONE: begin
        word_done = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_l) begin
    if (sys_rst_l) begin
      word_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      trim_q <= 1'b0;
      msb_q  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          word_q <= D_reg;
          trim_q <= mode_trim;
          msb_q  <= msb_first;
          cnt    <= '0;
          len_q  <= mode_trim ? trim_len : CNT_W'(N_BYTES);
        end
        S_WAIT: if (xmit_done && !last_byte) cnt <= cnt + CNT_W'(1);
        S_DONE: cnt <= '0;
        default: ;
      endcase
    end
  end

  assign byte_idx  = cnt;
  assign state_dbg = {trim_q, msb_q, state};

endmodule

// File: tb/tb_ftu_word_serializer.sv
module tb_ftu_word_serializer;
  localparam int BYTE_W = 8;
  localparam int N_BYTES = 8;
  localparam int MIN_BYTES = 4;
  localparam int CNT_W = $clog2(N_BYTES + 1);
  localparam int WORD_W = N_BYTES * BYTE_W;

  logic              sys_clk = 1'b0;
  logic              sys_rst_l = 1'b1;
  logic              pndng = 1'b0;
  logic [WORD_W-1:0] D_reg = '0;
  logic              pop;
  logic              mode_trim = 1'b0;
  logic              msb_first = 1'b0;
  logic [BYTE_W-1:0] Dout;
  logic              xmit;
  logic              xmit_done;
  logic              busy;
  logic              word_done;
  logic [CNT_W-1:0]  byte_idx;
  logic [4:0]        state_dbg;

  ftu_word_serializer #(
    .BYTE_W(BYTE_W), .N_BYTES(N_BYTES), .MIN_BYTES(MIN_BYTES)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .pndng(pndng), .D_reg(D_reg),
    .pop(pop), .mode_trim(mode_trim), .msb_first(msb_first), .Dout(Dout),
    .xmit(xmit), .xmit_done(xmit_done), .busy(busy), .word_done(word_done),
    .byte_idx(byte_idx), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model
  logic [WORD_W-1:0] fifo_q[$];
  always @(posedge sys_clk) begin
    if (pop && fifo_q.size() != 0) begin
      D_reg <= fifo_q.pop_front();
      pndng <= (fifo_q.size() != 0);
    end
  end

  // xmit model: one-cycle done pulse a fixed delay after each xmit strobe
  logic [3:0] xm_cd;
  logic       done_m;
  logic       force_en = 1'b0;
  logic       pop_d;
  always @(posedge sys_clk or posedge sys_rst_l) begin
    if (sys_rst_l) begin
      xm_cd  <= '0;
      done_m <= 1'b0;
      pop_d  <= 1'b0;
    end else begin
      pop_d  <= pop;
      done_m <= 1'b0;
      if (xmit) xm_cd <= 4'd5;
      else if (xm_cd != 0) begin
        xm_cd <= xm_cd - 4'd1;
        if (xm_cd == 4'd1) done_m <= 1'b1;
      end
    end
  end
  // pop_d marks the LOAD cycle, xmit marks START: the forced done lands in both
  assign xmit_done = done_m | (force_en & (xmit | pop_d));

  // scoreboard
  logic [BYTE_W-1:0] exp_q[$];
  int                len_q[$];
  int                sent_in_word = 0;
  int                xmit_total = 0;
  int                pop_cnt = 0;
  int                cyc = 0;
  int                wd_cyc = 0;
  bit                wd_seen = 0;
  bit                b2b_chk = 0;
  logic [BYTE_W-1:0] cur_byte = '0;

  task automatic push_word(input logic [WORD_W-1:0] w, input bit trim, input bit msb);
    int hi;
    int len;
    int idx;
    logic [BYTE_W-1:0] b;
    hi = 0;
    for (int i = 0; i < N_BYTES; i++) if (w[i*BYTE_W +: BYTE_W] != 0) hi = i + 1;
    len = trim ? ((hi < MIN_BYTES) ? MIN_BYTES : hi) : N_BYTES;
    for (int k = 0; k < len; k++) begin
      idx = msb ? (len - 1 - k) : k;
      b = w[idx*BYTE_W +: BYTE_W];
      exp_q.push_back(b);
    end
    len_q.push_back(len);
    fifo_q.push_back(w);
    pndng = 1'b1;
  endtask

  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst_l) begin
      sent_in_word = 0;
    end else begin
      if (xmit) begin
        if (exp_q.size() == 0) chk("unexpected_xmit", 1, 0);
        else chk("dout", Dout, exp_q.pop_front());
        chk("byte_idx", byte_idx, sent_in_word);
        sent_in_word++;
        xmit_total++;
        cur_byte = Dout;
      end
      if (done_m) chk("dout_hold", Dout, cur_byte);
      if (word_done) begin
        if (len_q.size() == 0) chk("unexpected_word_done", 1, 0);
        else chk("word_len", sent_in_word, len_q.pop_front());
        sent_in_word = 0;
        wd_cyc = cyc;
        wd_seen = 1;
      end
      if (pop) begin
        pop_cnt++;
        if (b2b_chk && wd_seen) chk("b2b_gap", cyc - wd_cyc, 2);
        wd_seen = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge sys_clk);
    while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_xmits(input int target, input int budget);
    int n;
    n = 0;
    while (xmit_total < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= budget) chk("xmit_wait_timeout", 1, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pop"}, pop, 0);
    chk({tag, "_xmit"}, xmit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_word_done"}, word_done, 0);
    chk({tag, "_dout"}, Dout, 0);
    chk({tag, "_byte_idx"}, byte_idx, 0);
  endtask

  int p0;
  int x0;

  initial begin
    repeat (3) @(negedge sys_clk);
    chk_outputs_zero("rst");
    sys_rst_l = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk_outputs_zero("idle");

    // 1: full, LSB first
    p0 = pop_cnt;
    mode_trim = 0; msb_first = 0;
    push_word(64'h0807060504030201, 0, 0);
    wait_drain("t1", 200);
    chk("t1_pops", pop_cnt - p0, 1);

    // 2: trim, LSB first
    p0 = pop_cnt;
    mode_trim = 1; msb_first = 0;
    push_word(64'h00000000A1B2C3D4, 1, 0);
    wait_drain("t2", 200);
    chk("t2_pops", pop_cnt - p0, 1);

    // 3: trim, MSB first, then all-zero word
    mode_trim = 1; msb_first = 1;
    push_word(64'h0000110000000022, 1, 1);
    wait_drain("t3a", 200);
    push_word(64'h0, 1, 1);
    wait_drain("t3b", 200);

    // 4: reset after the third xmit
    mode_trim = 0; msb_first = 0;
    x0 = xmit_total;
    push_word(64'h1122334455667788, 0, 0);
    wait_xmits(x0 + 3, 200);
    @(posedge sys_clk);
    #2 sys_rst_l = 1'b1;
    #1 chk_outputs_zero("midreset");
    exp_q.delete();
    len_q.delete();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_l = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("t4_no_repop", busy, 0);
    p0 = pop_cnt;
    push_word(64'h00000000000000C5, 0, 0);
    wait_drain("t4", 200);
    chk("t4_pops", pop_cnt - p0, 1);

    // 5: three words queued, pndng held high
    p0 = pop_cnt;
    wd_seen = 0;
    b2b_chk = 1;
    mode_trim = 1; msb_first = 0;
    for (int i = 0; i < 3; i++)
      push_word({32'h0, 8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))}, 1, 0);
    wait_drain("t5", 600);
    chk("t5_pops", pop_cnt - p0, 3);
    b2b_chk = 0;

    // 6: forced done in LOAD/START, mode_trim flipped mid-word
    force_en = 1;
    mode_trim = 1; msb_first = 1;
    x0 = xmit_total;
    push_word(64'h00000000000000AB, 1, 1);
    wait_xmits(x0 + 2, 200);
    mode_trim = 0;
    msb_first = 0;
    wait_drain("t6", 200);
    chk("t6_xmits", xmit_total - x0, 4);
    force_en = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
